osd_overlay: RTL

// Parametrised on-screen-display overlay. Sits in the video path between the core's RGB output and
// the scaler/HDMI encoder. Centres a 1-bpp bitmap window on the incoming picture, with a border and
// a drop shadow. A byte-stream command interface sets visibility, foreground colour and bitmap

---
 rtl/osd_overlay.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/osd_overlay.sv
// osd_overlay -- on-screen-display overlay for the RGB video path.
//
// Centres a WCHARS x HCHARS character (1 bpp) bitmap window on the incoming
// picture, scaled by SCALE, with a tinted border and a drop shadow. A byte
// command stream controls visibility, foreground colour and bitmap contents.
//
// Ports
//   clk             pixel clock
//   reset           synchronous, active-high
//   data_in_strobe  one-cycle qualifier for data_in
//   data_in_start   with strobe: data_in is a command byte (aborts any transfer)
//   data_in [7:0]   command / payload byte
//   hs, vs          active-low sync pulses
//   r_in/g_in/b_in  source pixel, CB bits per channel
//   r_out/g_out/b_out overlaid pixel, combinational from inputs and registers
module osd_overlay #(
   parameter int CB     = 6,
   parameter int WCHARS = 16,
   parameter int HCHARS = 8,
   parameter int SCALE  = 2,
   parameter int BORDER = 2,
   parameter int SHADOW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          data_in_strobe,
   input  logic          data_in_start,
   input  logic [7:0]    data_in,
   input  logic          hs,
   input  logic          vs,
   input  logic [CB-1:0] r_in,
   input  logic [CB-1:0] g_in,
   input  logic [CB-1:0] b_in,
   output logic [CB-1:0] r_out,
   output logic [CB-1:0] g_out,
   output logic [CB-1:0] b_out
);

   localparam int HW     = 12;                     // raster counter width
   localparam int NROWS  = HCHARS * 8;
   localparam int NBYTES = WCHARS * NROWS;
   localparam int AW     = $clog2(NBYTES);
   localparam int SH     = $clog2(SCALE);
   localparam int TW     = 8 * WCHARS * SCALE;     // text width in screen pixels
   localparam int TH     = 8 * HCHARS * SCALE;
   localparam int BW     = BORDER * SCALE;
   localparam int SW     = SHADOW * SCALE;
   localparam logic [HW-1:0] HHALF = HW'(4 * WCHARS * SCALE);
   localparam logic [HW-1:0] VHALF = HW'(4 * HCHARS * SCALE);
   localparam logic [CB-1:0] G_TINT = CB'(1 << (CB - 2));

   typedef enum logic [2:0] {
      S_IDLE, S_VIS, S_COL_R, S_COL_G, S_COL_B, S_WR_ROW, S_WR_DATA, S_IGNORE
   } cmd_state_t;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------
   function automatic logic in_span(input logic [HW-1:0] c, input logic [HW-1:0] lo,
                                    input int len);
      return (c >= lo) && (c < lo + HW'(len));
   endfunction

   function automatic logic [CB-1:0] bg_rb(input logic [CB-1:0] c, input logic sh);
      return sh ? (c >> 4) : (c >> 3);
   endfunction

   function automatic logic [CB-1:0] bg_g(input logic [CB-1:0] c, input logic sh);
      return bg_rb(c, sh) | G_TINT;
   endfunction

   // ---------------------------------------------------------------------
   // Raster timing
   // ---------------------------------------------------------------------
   logic          hs_q;
   logic          vs_s_q, vs_s_d;       // vs as sampled at the last hs rising edge
   logic [HW-1:0] hcnt_q, hcnt_d, hcntl_q, hcntl_d;
   logic [HW-1:0] vcnt_q, vcnt_d, vcntl_q, vcntl_d;
   logic          hs_rise, vs_fall;

   always_comb begin
      hs_rise = hs & ~hs_q;
      vs_fall = hs_rise & vs_s_q & ~vs;
      vs_s_d  = hs_rise ? vs : vs_s_q;
      hcnt_d  = hs_rise ? '0 : hcnt_q + 1'b1;
      hcntl_d = hs_rise ? hcnt_q : hcntl_q;
      vcnt_d  = vcnt_q;
      vcntl_d = vcntl_q;
      if (hs_rise) begin
         vcnt_d = vs_fall ? '0 : vcnt_q + 1'b1;
         if (vs_fall)
            vcntl_d = vcnt_q;
      end
   end

   // Counters are relocked by the video itself, so only the edge samplers reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q   <= 1'b1;
         vs_s_q <= 1'b1;
      end else begin
         hs_q   <= hs;
         vs_s_q <= vs_s_d;
      end
      hcnt_q  <= hcnt_d;
      hcntl_q <= hcntl_d;
      vcnt_q  <= vcnt_d;
      vcntl_q <= vcntl_d;
   end

   // ---------------------------------------------------------------------
   // Command decoder
   // ---------------------------------------------------------------------
   cmd_state_t    state_q, state_d;
   logic          enabled_q, enabled_d;
   logic [CB-1:0] fg_r_q, fg_r_d, fg_g_q, fg_g_d, fg_b_q, fg_b_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic          we;

   always_comb begin
      state_d   = state_q;
      enabled_d = enabled_q;
      fg_r_d    = fg_r_q;
      fg_g_d    = fg_g_q;
      fg_b_d    = fg_b_q;
      wr_ptr_d  = wr_ptr_q;
      we        = 1'b0;
      if (data_in_strobe) begin
         if (data_in_start) begin
            case (data_in)
               8'h01:   state_d = S_VIS;
               8'h02:   state_d = S_COL_R;
               8'h03:   state_d = S_WR_ROW;
               default: state_d = S_IGNORE;
            endcase
         end else begin
            case (state_q)
               S_VIS: begin
                  enabled_d = data_in[0];
                  state_d   = S_IGNORE;
               end
               S_COL_R: begin
                  fg_r_d  = data_in[CB-1:0];
                  state_d = S_COL_G;
               end
               S_COL_G: begin
                  fg_g_d  = data_in[CB-1:0];
                  state_d = S_COL_B;
               end
               S_COL_B: begin
                  fg_b_d  = data_in[CB-1:0];
                  state_d = S_IGNORE;
               end
               S_WR_ROW: begin
                  // Out-of-range start rows fall back to the top of the bitmap.
                  wr_ptr_d = (int'(data_in) >= NROWS) ? '0 : AW'(int'(data_in) * WCHARS);
                  state_d  = S_WR_DATA;
               end
               S_WR_DATA: begin
                  we       = 1'b1;
                  wr_ptr_d = (wr_ptr_q == AW'(NBYTES - 1)) ? '0 : wr_ptr_q + 1'b1;
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         enabled_q <= 1'b0;
         fg_r_q    <= '1;
         fg_g_q    <= '1;
         fg_b_q    <= '1;
         wr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         enabled_q <= enabled_d;
         fg_r_q    <= fg_r_d;
         fg_g_q    <= fg_g_d;
         fg_b_q    <= fg_b_d;
         wr_ptr_q  <= wr_ptr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Bitmap RAM: the read address is formed from next-cycle raster state so
   // the byte arrives exactly on the pixel that uses it. A same-address write
   // and read in one cycle returns the old byte.
   // ---------------------------------------------------------------------
   logic [7:0]    bitmap_q [NBYTES];
   logic [7:0]    rd_q;
   logic [HW-1:0] hstart_n, vstart_n;
   logic [AW-1:0] raddr;

   always_comb begin
      hstart_n = (hcntl_d >> 1) - HHALF;
      vstart_n = (vcntl_d >> 1) - VHALF;
      raddr    = AW'((((vcnt_d - vstart_n) >> SH) * HW'(WCHARS))
                     + (((hcnt_d - hstart_n) >> SH) >> 3));
   end

   always_ff @(posedge clk) begin
      if (we)
         bitmap_q[wr_ptr_q] <= data_in;
      rd_q <= bitmap_q[raddr];
   end

   // ---------------------------------------------------------------------
   // Window geometry and pixel mixing
   // ---------------------------------------------------------------------
   logic [HW-1:0] hstart, vstart;
   logic [2:0]    pxb;
   logic          in_text, in_active, in_shadow, pix_bit;

   always_comb begin
      hstart    = (hcntl_q >> 1) - HHALF;
      vstart    = (vcntl_q >> 1) - VHALF;
      in_text   = in_span(hcnt_q, hstart, TW) && in_span(vcnt_q, vstart, TH);
      in_active = in_span(hcnt_q, hstart - HW'(BW), TW + 2 * BW)
               && in_span(vcnt_q, vstart - HW'(BW), TH + 2 * BW);
      in_shadow = in_span(hcnt_q, hstart - HW'(BW) + HW'(SW), TW + 2 * BW)
               && in_span(vcnt_q, vstart - HW'(BW) + HW'(SW), TH + 2 * BW);
      pxb       = 3'((hcnt_q - hstart) >> SH);
      pix_bit   = rd_q[3'd7 - pxb];

      r_out = r_in;
      g_out = g_in;
      b_out = b_in;
      if (enabled_q) begin
         if (in_text && pix_bit) begin
            r_out = fg_r_q;
            g_out = fg_g_q;
            b_out = fg_b_q;
         end else if (in_active) begin
            r_out = bg_rb(r_in, in_shadow);
            g_out = bg_g(g_in, in_shadow);
            b_out = bg_rb(b_in, in_shadow);
         end else if (in_shadow) begin
            r_out = r_in >> 1;
            g_out = g_in >> 1;
            b_out = b_in >> 1;
         end
      end
   end

endmodule
